dice_roller: RTL and testbench

DICE_ROLLER -- requirements
Module: dice_roller

---
 rtl/dice_roller_if.sv | 15 +
 rtl/dice_roller.sv | 159 +++++++++++++++
 tb/tb_dice_roller.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dice_roller_if.sv
// Button/mode/sides in, BCD result and status out, for the dice roller.
interface dice_roller_if #(
  parameter int DIGITS = 3
);
  logic                  btn;
  logic                  mode;
  logic [4*DIGITS-1:0]   sides;
  logic [4*DIGITS-1:0]   value;
  logic                  busy;
  logic                  valid;
  logic                  err;

  modport master (output btn, mode, sides, input value, busy, valid, err);
  modport slave  (input btn, mode, sides, output value, busy, valid, err);
endinterface

// File: rtl/dice_roller.sv
// Dice roller: debounced button starts a BCD random roll (press..release) or a countdown step.
// Press/release act DEB_SAMPLES ticks after btn settles; no backpressure, results hold until the next press.
module dice_roller #(
  parameter int DIGITS      = 3,
  parameter int PRESC_BITS  = 10,
  parameter int DEB_SAMPLES = 3
) (
  input logic          clk,
  input logic          rst_n,
  dice_roller_if.slave io
);
  localparam int             W       = 4 * DIGITS;
  localparam logic [W-1:0]   BCD_ONE = W'(1);
  localparam logic [W-1:0]   BCD_TWO = W'(2);

  typedef enum logic [1:0] {IDLE, ROLL, SHOW} state_t;

  state_t                  state, state_n;
  logic                    btn_s1, btn_s2;
  logic [PRESC_BITS-1:0]   presc;
  logic                    tick;
  logic [DEB_SAMPLES-1:0]  deb_sh, deb_sh_n;
  logic                    deb_lvl, deb_lvl_d;
  logic                    press_pls, rel_pls;
  logic [W-1:0]            value_q, value_n, lim, lim_n, cnt, cnt_n;
  logic                    valid_q, valid_n, err_q, err_n;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] x);
    logic [W-1:0] r;
    logic         c;
    r = x;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] x);
    logic [W-1:0] r;
    logic         b;
    r = x;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Packed BCD with legal nibbles orders like binary, so >= 2 is a plain compare.
  function automatic logic sides_ok(input logic [W-1:0] x);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (x[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok && (x >= BCD_TWO);
  endfunction

  assign tick      = (presc == '0);
  assign deb_sh_n  = {deb_sh[DEB_SAMPLES-2:0], btn_s2};
  assign press_pls = deb_lvl & ~deb_lvl_d;
  assign rel_pls   = ~deb_lvl & deb_lvl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      presc     <= '0;
      deb_sh    <= '0;
      deb_lvl   <= 1'b0;
      deb_lvl_d <= 1'b0;
    end else begin
      btn_s1    <= io.btn;
      btn_s2    <= btn_s1;
      presc     <= presc + 1'b1;
      deb_lvl_d <= deb_lvl;
      if (tick) begin
        deb_sh <= deb_sh_n;
        if (&deb_sh_n)       deb_lvl <= 1'b1;
        else if (~|deb_sh_n) deb_lvl <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      value_q <= BCD_ONE;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      lim     <= '0;
      cnt     <= BCD_ONE;
    end else begin
      state   <= state_n;
      value_q <= value_n;
      valid_q <= valid_n;
      err_q   <= err_n;
      lim     <= lim_n;
      cnt     <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    value_n = value_q;
    valid_n = valid_q;
    err_n   = err_q;
    lim_n   = lim;
    cnt_n   = cnt;
    case (state)
      IDLE, SHOW: begin
        if (press_pls) begin
          if (!sides_ok(io.sides)) begin
            err_n = 1'b1;
          end else begin
            err_n = 1'b0;
            lim_n = io.sides;
            if (!io.mode) begin
              cnt_n   = BCD_ONE;
              valid_n = 1'b0;
              state_n = ROLL;
            end else begin
              valid_n = 1'b1;
              state_n = SHOW;
              if (value_q == BCD_ONE || value_q > io.sides) value_n = io.sides;
              else                                          value_n = bcd_dec(value_q);
            end
          end
        end
      end
      ROLL: begin
        cnt_n = (cnt == lim) ? BCD_ONE : bcd_inc(cnt);
        if (rel_pls) begin
          value_n = cnt;
          valid_n = 1'b1;
          state_n = SHOW;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign io.value = value_q;
  assign io.busy  = (state == ROLL);
  assign io.valid = valid_q;
  assign io.err   = err_q;
endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller: idle/glitch, rolls with length model, countdown, bad sides, reset mid-roll.
module tb_dice_roller;
  localparam int DIGITS      = 3;
  localparam int PRESC_BITS  = 3;
  localparam int DEB_SAMPLES = 3;
  localparam int TICK        = 1 << PRESC_BITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dice_roller_if #(.DIGITS(DIGITS)) dif ();

  dice_roller #(
    .DIGITS     (DIGITS),
    .PRESC_BITS (PRESC_BITS),
    .DEB_SAMPLES(DEB_SAMPLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (dif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] value;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   seen7[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [11:0] v, input logic vl, input logic e);
    exp_t x;
    x.value = v;
    x.valid = vl;
    x.err   = e;
    sb.push_back(x);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, ".value"}, 32'(dif.value), 32'(e.value));
    chk({tag, ".valid"}, 32'(dif.valid), 32'(e.valid));
    chk({tag, ".err"},   32'(dif.err),   32'(e.err));
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit bcd_in_range(input logic [11:0] v, input int hi);
    int n;
    if (v[11:8] > 4'd9 || v[7:4] > 4'd9 || v[3:0] > 4'd9) return 1'b0;
    n = int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    return (n >= 1) && (n <= hi);
  endfunction

  // Short press: hold long enough to debounce, release, let the low level settle.
  task automatic press_once(output bit saw_busy);
    saw_busy = 1'b0;
    dif.btn  = 1'b1;
    for (int t = 0; t < 5 * TICK; t++) begin
      cyc(1);
      if (dif.busy) saw_busy = 1'b1;
    end
    dif.btn = 1'b0;
    for (int t = 0; t < 5 * TICK; t++) begin
      cyc(1);
      if (dif.busy) saw_busy = 1'b1;
    end
  endtask

  // Roll: n counts clocks spent busy, which fixes the expected face.
  task automatic roll(input int hold, output int n, output bit busy_mid);
    n       = 0;
    dif.btn = 1'b1;
    for (int t = 0; t < hold; t++) begin
      cyc(1);
      if (dif.busy) n++;
    end
    busy_mid = dif.busy;
    dif.btn  = 1'b0;
    for (int t = 0; t < 10 * TICK; t++) begin
      cyc(1);
      if (dif.busy) n++;
      else break;
    end
    chk("roll_done_busy", 32'(dif.busy), 32'd0);
    cyc(2);
  endtask

  task automatic roll_and_score(input string tag, input int hold, input int lim, output bit busy_mid);
    int n;
    int face;
    roll(hold, n, busy_mid);
    face = (n > 0) ? ((n - 1) % lim) + 1 : 0;
    sb_push(to_bcd(face), 1'b1, 1'b0);
    chk({tag, ".range"}, 32'(bcd_in_range(dif.value, lim)), 32'd1);
    sb_check(tag);
    if (lim == 7 && face >= 1 && face <= 7) seen7[face] = 1'b1;
  endtask

  initial begin
    bit saw;
    bit mid;
    int first;

    dif.btn   = 1'b0;
    dif.mode  = 1'b0;
    dif.sides = 12'h006;
    rst_n     = 1'b0;
    cyc(3);
    chk("rst.value", 32'(dif.value), 32'h001);
    chk("rst.valid", 32'(dif.valid), 32'd0);
    chk("rst.busy",  32'(dif.busy),  32'd0);
    chk("rst.err",   32'(dif.err),   32'd0);
    rst_n = 1'b1;

    // Idle with btn low: nothing may happen.
    saw = 1'b0;
    for (int t = 0; t < 200; t++) begin
      cyc(1);
      if (dif.busy) saw = 1'b1;
    end
    chk("idle_busy_seen", 32'(saw), 32'd0);
    sb_push(12'h001, 1'b0, 1'b0);
    sb_check("idle");

    // One-tick glitch is rejected.
    dif.btn = 1'b1;
    cyc(TICK);
    dif.btn = 1'b0;
    saw = 1'b0;
    for (int t = 0; t < 8 * TICK; t++) begin
      cyc(1);
      if (dif.busy) saw = 1'b1;
    end
    chk("glitch_busy_seen", 32'(saw), 32'd0);
    sb_push(12'h001, 1'b0, 1'b0);
    sb_check("glitch");

    // Random rolls on a d20.
    dif.sides = 12'h020;
    dif.mode  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i == 0) begin
        roll_and_score("roll20", 10 * TICK, 20, mid);
        chk("roll_busy_during_hold", 32'(mid), 32'd1);
      end else begin
        roll_and_score("roll20", 5 * TICK + (i % 14) * TICK + int'($urandom_range(0, 7)), 20, mid);
      end
    end

    // Press and release are tick-aligned, so roll lengths step by TICK;
    // a limit coprime to TICK reaches every face as the hold sweeps.
    dif.sides = 12'h007;
    for (int k = 0; k < 21; k++) roll_and_score("roll7", 5 * TICK + k * TICK, 7, mid);
    for (int v = 1; v <= 7; v++) chk($sformatf("cover7_face%0d", v), 32'(seen7[v]), 32'd1);

    // Countdown from reset.
    rst_n = 1'b0;
    cyc(2);
    rst_n     = 1'b1;
    dif.mode  = 1'b1;
    dif.sides = 12'h100;
    sb_push(12'h100, 1'b1, 1'b0); press_once(saw); chk("cd1_busy", 32'(saw), 32'd0); sb_check("cd1");
    sb_push(12'h099, 1'b1, 1'b0); press_once(saw); sb_check("cd2");
    sb_push(12'h098, 1'b1, 1'b0); press_once(saw); sb_check("cd3");
    dif.sides = 12'h002;
    sb_push(12'h002, 1'b1, 1'b0); press_once(saw); sb_check("cd_above_lim");
    sb_push(12'h001, 1'b1, 1'b0); press_once(saw); sb_check("cd_to_one");
    dif.sides = 12'h100;
    sb_push(12'h100, 1'b1, 1'b0); press_once(saw); sb_check("cd_wrap");

    // Invalid sides are rejected without touching value/valid.
    dif.mode  = 1'b0;
    dif.sides = 12'h0A5;
    sb_push(12'h100, 1'b1, 1'b1); press_once(saw); chk("bad_nibble_busy", 32'(saw), 32'd0); sb_check("bad_nibble");
    dif.sides = 12'h001;
    sb_push(12'h100, 1'b1, 1'b1); press_once(saw); chk("bad_one_busy", 32'(saw), 32'd0); sb_check("bad_one");
    dif.mode  = 1'b1;
    dif.sides = 12'h012;
    sb_push(12'h012, 1'b1, 1'b0); press_once(saw); sb_check("good_after_bad");

    // Reset in the middle of a roll with btn held.
    dif.mode  = 1'b0;
    dif.sides = 12'h020;
    dif.btn   = 1'b1;
    saw = 1'b0;
    for (int t = 0; t < 8 * TICK; t++) begin
      cyc(1);
      if (dif.busy) begin
        saw = 1'b1;
        break;
      end
    end
    chk("mid_roll_started", 32'(saw), 32'd1);
    cyc(20);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.value", 32'(dif.value), 32'h001);
    chk("mid_rst.busy",  32'(dif.busy),  32'd0);
    chk("mid_rst.valid", 32'(dif.valid), 32'd0);
    chk("mid_rst.err",   32'(dif.err),   32'd0);
    cyc(3);
    rst_n = 1'b1;
    first = 0;
    for (int k = 1; k <= 12 * TICK; k++) begin
      cyc(1);
      if (dif.busy && first == 0) first = k;
    end
    chk($sformatf("post_rst_busy_at_%0d", first),
        32'((first >= DEB_SAMPLES * TICK) && (first <= DEB_SAMPLES * TICK + 3)), 32'd1);
    dif.btn = 1'b0;
    cyc(8 * TICK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
